// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipeline.
//
// Takes the execute-stage bundle. A non-memory op is written back on the next
// cycle. A misaligned memory op issues no request and is written back with a
// misalign flag. An aligned load or store makes one transaction over a
// valid/ready data-memory port. Load data is lane-selected and extended before
// writeback. in_ready is low for the whole time an access is outstanding.
//
// Ports:
//   clk, arst_n               clock, asynchronous active-low reset
//   in_valid / in_ready       EX bundle handshake (ready only when idle)
//   opr_res, opr_b            ALU result / byte address, store data
//   rd, rf_en                 destination register, register write request
//   dm_en, wb_sel             store request, load request (memory data to WB)
//   lsuop                     000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_req_valid/_ready     request handshake
//   dmem_addr, dmem_we        word-aligned address, write request
//   dmem_wdata, dmem_be       lane-replicated store data, byte enables
//   dmem_rsp_valid, dmem_rdata  response strobe (load data or store ack), load word
//   wb_valid                  one-cycle writeback pulse
//   wb_rd, wb_rf_en, wb_data  writeback destination, enable, value
//   wb_misalign               misaligned-access flag
module mem_stage #(
  parameter int unsigned DATA_WIDTH = 32,  // only 32 is supported
  parameter int unsigned ADDR_WIDTH = 32   // must not exceed DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] opr_res,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic [4:0]            rd,
  input  logic                  rf_en,
  input  logic                  dm_en,
  input  logic                  wb_sel,
  input  logic [2:0]            lsuop,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic                  wb_rf_en,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e state_q, state_d;

  // Operation latched at accept, used when the response arrives.
  logic [2:0]            lsuop_q, lsuop_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rf_en_q, rf_en_d;
  logic                  store_q, store_d;

  // Registered request fields, held stable while in StReq.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;

  // Registered writeback bundle.
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  wb_rf_en_q, wb_rf_en_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_misalign_q, wb_misalign_d;

  logic                  accept;
  logic                  is_mem;
  logic                  size_byte, size_half, size_word;
  logic                  misalign;
  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  rsp_done;

  assign in_ready       = (state_q == StIdle);
  assign dmem_req_valid = (state_q == StReq);
  assign accept         = in_valid & in_ready;
  assign is_mem         = dm_en | wb_sel;
  assign rsp_done       = (state_q == StWait) & dmem_rsp_valid;

  // Access size comes from lsuop[1:0]; the reserved code 11 is treated as a word.
  assign size_byte = (lsuop[1:0] == 2'b00);
  assign size_half = (lsuop[1:0] == 2'b01);
  assign size_word = ~size_byte & ~size_half;
  assign misalign  = (size_half & opr_res[0]) | (size_word & (|opr_res[1:0]));

  // Store lanes: the narrow operand is replicated across the word, and the byte
  // enables pick the lane. Loads always read the full word.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = '0;
    if (dm_en) begin
      if (size_byte) begin
        req_be    = 4'b0001 << opr_res[1:0];
        req_wdata = {4{opr_b[7:0]}};
      end else if (size_half) begin
        req_be    = 4'b0011 << opr_res[1:0];
        req_wdata = {2{opr_b[15:0]}};
      end else begin
        req_wdata = opr_b;
      end
    end
  end

  // Move the addressed lane down to bit 0, then extend.
  assign rdata_shifted = dmem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    unique case (lsuop_q[1:0])
      2'b00: begin
        if (lsuop_q[2]) begin
          load_data = {24'h000000, rdata_shifted[7:0]};
        end else begin
          load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
        end
      end
      2'b01: begin
        if (lsuop_q[2]) begin
          load_data = {16'h0000, rdata_shifted[15:0]};
        end else begin
          load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
        end
      end
      default: load_data = dmem_rdata;
    endcase
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && is_mem && !misalign) state_d = StReq;
      StReq:  if (dmem_req_ready) state_d = StWait;
      StWait: if (dmem_rsp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operation latch and request fields: loaded only when an aligned memory op
  // is accepted.
  always_comb begin
    lsuop_d   = lsuop_q;
    addr_lo_d = addr_lo_q;
    rd_d      = rd_q;
    rf_en_d   = rf_en_q;
    store_d   = store_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    if (accept && is_mem && !misalign) begin
      lsuop_d   = lsuop;
      addr_lo_d = opr_res[1:0];
      rd_d      = rd;
      rf_en_d   = rf_en;
      store_d   = dm_en;
      addr_d    = {opr_res[ADDR_WIDTH-1:2], 2'b00};
      we_d      = dm_en;
      wdata_d   = req_wdata;
      be_d      = req_be;
    end
  end

  // Writeback bundle. Fields hold between completions; only wb_valid pulses.
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_rf_en_d    = wb_rf_en_q;
    wb_data_d     = wb_data_q;
    wb_misalign_d = wb_misalign_q;
    if (accept && !is_mem) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = rd;
      wb_rf_en_d    = rf_en & (rd != 5'd0);
      wb_data_d     = opr_res;
      wb_misalign_d = 1'b0;
    end else if (accept && misalign) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = rd;
      wb_rf_en_d    = 1'b0;
      wb_data_d     = opr_res;
      wb_misalign_d = 1'b1;
    end else if (rsp_done) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = rd_q;
      wb_misalign_d = 1'b0;
      if (store_q) begin
        wb_rf_en_d = 1'b0;
        wb_data_d  = '0;
      end else begin
        wb_rf_en_d = rf_en_q & (rd_q != 5'd0);
        wb_data_d  = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= StIdle;
      lsuop_q       <= 3'b000;
      addr_lo_q     <= 2'b00;
      rd_q          <= 5'd0;
      rf_en_q       <= 1'b0;
      store_q       <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= 4'b0000;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_rf_en_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lsuop_q       <= lsuop_d;
      addr_lo_q     <= addr_lo_d;
      rd_q          <= rd_d;
      rf_en_q       <= rf_en_d;
      store_q       <= store_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_rf_en_q    <= wb_rf_en_d;
      wb_data_q     <= wb_data_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  assign dmem_addr   = addr_q;
  assign dmem_we     = we_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_rf_en    = wb_rf_en_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opr_res;
  logic [31:0] opr_b;
  logic [4:0]  rd;
  logic        rf_en;
  logic        dm_en;
  logic        wb_sel;
  logic [2:0]  lsuop;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_rf_en;
  logic [31:0] wb_data;
  logic        wb_misalign;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opr_res        (opr_res),
    .opr_b          (opr_b),
    .rd             (rd),
    .rf_en          (rf_en),
    .dm_en          (dm_en),
    .wb_sel         (wb_sel),
    .lsuop          (lsuop),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_rf_en       (wb_rf_en),
    .wb_data        (wb_data),
    .wb_misalign    (wb_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one outstanding access at most.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rf_en;
    logic        store;
    logic [2:0]  op;
  } op_t;

  bit          busy;
  bit          req_pending;
  op_t         cur;
  bit          exp_wb_valid;
  logic [4:0]  exp_wb_rd;
  bit          exp_wb_rf_en;
  logic [31:0] exp_wb_data;
  bit          exp_wb_mis;
  int          rsp_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] v;
    sz = size_of(op);
    v  = rdata >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!op[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!op[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    int unsigned sz;
    if (!o.store) return 4'hF;
    sz = size_of(o.op);
    return 4'(((1 << sz) - 1) << (o.addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    int unsigned sz;
    sz = size_of(o.op);
    if (sz == 1) return 32'(o.b[7:0]) * 32'h01010101;
    if (sz == 2) return 32'(o.b[15:0]) * 32'h00010001;
    return o.b;
  endfunction

  task automatic model_reset();
    busy         = 0;
    req_pending  = 0;
    exp_wb_valid = 0;
    rsp_wait     = 0;
  endtask

  // Advance the model by the clock edge about to happen, using current inputs.
  task automatic model_step();
    exp_wb_valid = 0;
    if (!busy && in_valid) begin
      if (!(dm_en || wb_sel)) begin
        exp_wb_valid = 1;
        exp_wb_rd    = rd;
        exp_wb_rf_en = rf_en && (rd != 0);
        exp_wb_data  = opr_res;
        exp_wb_mis   = 0;
      end else if ((opr_res % size_of(lsuop)) != 0) begin
        exp_wb_valid = 1;
        exp_wb_rd    = rd;
        exp_wb_rf_en = 0;
        exp_wb_data  = opr_res;
        exp_wb_mis   = 1;
      end else begin
        busy        = 1;
        req_pending = 1;
        cur.addr    = opr_res;
        cur.b       = opr_b;
        cur.rd      = rd;
        cur.rf_en   = rf_en;
        cur.store   = dm_en;
        cur.op      = lsuop;
      end
    end else if (busy && req_pending) begin
      if (dmem_req_ready) begin
        req_pending = 0;
        rsp_wait    = $urandom_range(0, 3);
      end
    end else if (busy && dmem_rsp_valid) begin
      busy         = 0;
      exp_wb_valid = 1;
      exp_wb_rd    = cur.rd;
      exp_wb_mis   = 0;
      if (cur.store) begin
        exp_wb_rf_en = 0;
        exp_wb_data  = 0;
      end else begin
        exp_wb_rf_en = cur.rf_en && (cur.rd != 0);
        exp_wb_data  = load_value(cur.op, cur.addr, dmem_rdata);
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(!busy));
    chk("req_valid", 32'(dmem_req_valid), 32'(req_pending));
    if (req_pending) begin
      chk("req_addr", dmem_addr, cur.addr & 32'hFFFFFFFC);
      chk("req_we", 32'(dmem_we), 32'(cur.store));
      chk("req_be", 32'(dmem_be), 32'(exp_be(cur)));
      if (cur.store) chk("req_wdata", dmem_wdata, exp_wdata(cur));
    end
    chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
    if (exp_wb_valid) begin
      chk("wb_rf_en", 32'(wb_rf_en), 32'(exp_wb_rf_en));
      chk("wb_data", wb_data, exp_wb_data);
      chk("wb_misalign", 32'(wb_misalign), 32'(exp_wb_mis));
      if (exp_wb_rf_en) chk("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
    end
  endtask

  // Inputs are set at a falling edge; tick consumes them at the next rising edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive_op(input bit v, input logic [31:0] res, input logic [31:0] b,
                          input logic [4:0] r, input bit rfe, input bit dme, input bit wbs,
                          input logic [2:0] op);
    in_valid = v;
    opr_res  = res;
    opr_b    = b;
    rd       = r;
    rf_en    = rfe;
    dm_en    = dme;
    wb_sel   = wbs;
    lsuop    = op;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    chk({tag, "_req_valid"}, 32'(dmem_req_valid), 32'h0);
    chk({tag, "_we"}, 32'(dmem_we), 32'h0);
    chk({tag, "_be"}, 32'(dmem_be), 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'h0);
    chk({tag, "_wb_rf_en"}, 32'(wb_rf_en), 32'h0);
    chk({tag, "_wb_data"}, wb_data, 32'h0);
    chk({tag, "_wb_mis"}, 32'(wb_misalign), 32'h0);
  endtask

  // Single load with an immediate grant and response.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] r,
                          input bit rfe, input logic [31:0] rdata);
    drive_op(1, addr, 32'h0, r, rfe, 0, 1, op);
    tick();
    in_valid       = 0;
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0;
    dmem_rsp_valid = 1;
    dmem_rdata     = rdata;
    tick();
    dmem_rsp_valid = 0;
  endtask

  logic [2:0] load_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    arst_n = 0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_req_ready = 0;
    dmem_rsp_valid = 0;
    dmem_rdata     = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arst_n = 1;

    // Non-memory ops, back to back.
    drive_op(1, 32'h1234, 0, 5'd5, 1, 0, 0, 3'b010);
    tick();
    chk("alu_wb_valid", 32'(wb_valid), 32'h1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rf_en", 32'(wb_rf_en), 32'h1);
    drive_op(1, 32'h55, 0, 5'd6, 1, 0, 0, 3'b000);
    tick();
    chk("alu2_wb_data", wb_data, 32'h55);
    chk("alu2_in_ready", 32'(in_ready), 32'h1);
    in_valid = 0;
    tick();
    chk("alu_idle_wb_valid", 32'(wb_valid), 32'h0);

    // SB to 0x103 with a grant withheld for three cycles.
    drive_op(1, 32'h103, 32'hAB, 5'd7, 1, 1, 0, 3'b000);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sb_addr", dmem_addr, 32'h100);
      chk("sb_be", 32'(dmem_be), 32'h8);
      chk("sb_wdata", dmem_wdata, 32'hABABABAB);
      chk("sb_we", 32'(dmem_we), 32'h1);
      chk("sb_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    chk("sb_req_valid_held", 32'(dmem_req_valid), 32'h1);
    dmem_req_ready = 1;
    tick();
    chk("sb_req_dropped", 32'(dmem_req_valid), 32'h0);
    dmem_req_ready = 0;
    dmem_rsp_valid = 1;
    tick();
    dmem_rsp_valid = 0;
    chk("sb_wb_valid", 32'(wb_valid), 32'h1);
    chk("sb_wb_rf_en", 32'(wb_rf_en), 32'h0);

    // Byte loads, signed and unsigned.
    run_load(32'h102, 3'b000, 5'd8, 1, 32'h00800000);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    run_load(32'h102, 3'b100, 5'd8, 1, 32'h00800000);
    chk("lbu_data", wb_data, 32'h00000080);

    // Misaligned half and word loads.
    drive_op(1, 32'h101, 0, 5'd9, 1, 0, 1, 3'b001);
    tick();
    chk("lh_mis_req", 32'(dmem_req_valid), 32'h0);
    chk("lh_mis_flag", 32'(wb_misalign), 32'h1);
    chk("lh_mis_rf_en", 32'(wb_rf_en), 32'h0);
    drive_op(1, 32'h102, 0, 5'd9, 1, 0, 1, 3'b010);
    tick();
    chk("lw_mis_req", 32'(dmem_req_valid), 32'h0);
    chk("lw_mis_flag", 32'(wb_misalign), 32'h1);
    chk("lw_mis_valid", 32'(wb_valid), 32'h1);
    in_valid = 0;
    tick();

    // Word load to x0.
    run_load(32'h200, 3'b010, 5'd0, 1, 32'hDEADBEEF);
    chk("lw_x0_data", wb_data, 32'hDEADBEEF);
    chk("lw_x0_rf_en", 32'(wb_rf_en), 32'h0);

    // Reset while waiting for the response.
    drive_op(1, 32'h300, 0, 5'd3, 1, 0, 1, 3'b010);
    tick();
    in_valid       = 0;
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0;
    chk("wait_in_ready", 32'(in_ready), 32'h0);
    #2;
    arst_n = 0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(negedge clk);
    arst_n         = 1;
    dmem_rsp_valid = 1;
    dmem_rdata     = 32'h12345678;
    tick();
    dmem_rsp_valid = 0;
    chk("late_rsp_wb_valid", 32'(wb_valid), 32'h0);
    drive_op(1, 32'h0BAD, 0, 5'd4, 1, 0, 0, 3'b000);
    tick();
    chk("post_rst_wb_data", wb_data, 32'h0BAD);
    in_valid = 0;
    tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind = $urandom_range(0, 2);
      in_valid = ($urandom_range(0, 9) < 6);
      opr_res  = $urandom;
      opr_b    = $urandom;
      rd       = 5'($urandom);
      rf_en    = 1'($urandom);
      if (kind == 0) begin
        dm_en  = 0;
        wb_sel = 0;
        lsuop  = 3'($urandom);
      end else if (kind == 1) begin
        dm_en  = 0;
        wb_sel = 1;
        lsuop  = load_ops[$urandom_range(0, 4)];
      end else begin
        dm_en  = 1;
        wb_sel = 0;
        lsuop  = 3'($urandom_range(0, 2));
      end
      // Bias addresses so a fair share of halves and words are aligned.
      if ($urandom_range(0, 1) == 1) opr_res[1:0] = 2'b00;
      dmem_req_ready = ($urandom_range(0, 2) != 0);
      dmem_rdata     = $urandom;
      if (busy && !req_pending) begin
        if (rsp_wait > 0) begin
          rsp_wait--;
          dmem_rsp_valid = 0;
        end else begin
          dmem_rsp_valid = 1;
        end
      end else begin
        dmem_rsp_valid = ($urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
